prog_uart_loader: RTL and testbench

Parametrised UART program loader: the successor to the fixed programming-UART path in the SoC top. Receives a serial byte stream on `rx_i` with an optional parity bit and assembles little-endian words of `WORD_W` bits. Each word is written to instruction memory through a ready/valid write port at incrementing addresses. A configurable end-of-program word stops the load and releases the core through `boot_o`. Framing, parity and overrun conditions are reported as sticky error flags.

---
 rtl/prog_uart_loader.sv | 213 +++++++++++++++++++++
 tb/tb_prog_uart_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_uart_loader.sv
// prog_uart_loader
//   UART program loader. Receives 8-bit frames (optional parity) on rx_i,
//   assembles little-endian WORD_W-bit words and writes them to instruction
//   memory at incrementing addresses through a ready/valid port. A word equal
//   to EOP_WORD ends the load and releases the core via boot_o.
// Ports:
//   clock, reset (async, active-low)
//   clk_per_bit            : cycles per UART bit (values below 4 act as 4)
//   rx_i, prog_i           : asynchronous serial line / programming request
//   parity_en, parity_odd  : parity bit present / odd parity select
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_ready_i : memory write port
//   boot_o                 : core release
//   frame_err_o, parity_err_o, overrun_err_o : sticky error flags
//   word_count_o           : words written in the current load (saturating)
module prog_uart_loader #(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DIV_W    = 16,
    parameter logic [31:0] EOP_WORD = 32'h0000_0FFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DIV_W-1:0]  clk_per_bit,
    input  logic              rx_i,
    input  logic              prog_i,
    input  logic              parity_en,
    input  logic              parity_odd,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              boot_o,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_err_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int unsigned       NB  = WORD_W / 8;
    localparam logic [WORD_W-1:0] EOP = WORD_W'(EOP_WORD);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_WRITE, L_DONE} ld_state_t;

    // ---------------- synchronisers ----------------
    logic       rx_meta, rx_s, rx_prev, prog_meta, prog_s;
    logic [1:0] warm;   // primes after the prog synchroniser has filled

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            prog_meta <= 1'b0;
            prog_s    <= 1'b0;
            warm      <= '0;
        end else begin
            rx_meta   <= rx_i;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            prog_meta <= prog_i;
            prog_s    <= prog_meta;
            warm      <= {warm[0], 1'b1};
        end
    end

    // ---------------- receiver ----------------
    rx_state_t        rx_state, rx_next;
    logic [DIV_W-1:0] div, half, cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par_bad, byte_valid;
    logic             tick_half, tick_full, parity_ev, frame_ev;

    assign div       = (clk_per_bit < DIV_W'(4)) ? DIV_W'(4) : clk_per_bit;
    assign half      = div >> 1;
    assign tick_half = (cnt == half - DIV_W'(1));
    assign tick_full = (cnt == div - DIV_W'(1));
    assign parity_ev = (rx_state == RX_PARITY) && tick_full && (rx_s != ((^shreg) ^ parity_odd));
    assign frame_ev  = (rx_state == RX_STOP) && tick_full && !rx_s;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START:  if (tick_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (tick_full && bit_cnt == 3'd7) rx_next = parity_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (tick_full) rx_next = RX_STOP;
            RX_STOP:   if (tick_full) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            byte_valid <= 1'b0;
            // Counter restarts on every state change and on every data bit,
            // so each sample lands mid-bit relative to the start-bit centre.
            if (rx_state == RX_IDLE || rx_next != rx_state || (rx_state == RX_DATA && tick_full))
                cnt <= '0;
            else
                cnt <= cnt + DIV_W'(1);
            case (rx_state)
                RX_START: begin
                    bit_cnt <= '0;
                    par_bad <= 1'b0;
                end
                RX_DATA: if (tick_full) begin
                    shreg   <= {rx_s, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                RX_PARITY: if (parity_ev) par_bad <= 1'b1;
                RX_STOP:   if (tick_full && rx_s && !par_bad) byte_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- loader ----------------
    ld_state_t         ld_state, ld_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [3:0]        idx;
    logic [WORD_W-1:0] word, word_next;
    logic              boot_q, boot_next, last_byte, accept;
    logic              frame_err, parity_err, overrun_err;

    assign last_byte = (32'(idx) == NB - 1);
    assign accept    = (ld_state == L_WRITE) && mem_ready_i;

    always_comb begin
        word_next = word;
        for (int unsigned i = 0; i < NB; i++)
            if (32'(idx) == i) word_next[8*i +: 8] = shreg;
    end

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            L_IDLE:  if (prog_s) ld_next = L_LOAD;
            L_LOAD: begin
                if (!prog_s) ld_next = L_IDLE;
                else if (byte_valid && last_byte) ld_next = (word_next == EOP) ? L_DONE : L_WRITE;
            end
            L_WRITE: if (accept) ld_next = prog_s ? L_LOAD : L_IDLE;
            L_DONE:  if (!prog_s) ld_next = L_IDLE;
            default: ld_next = L_IDLE;
        endcase
        // Registered so boot_o is 0 in reset and cannot rise before the
        // prog synchroniser holds a real value.
        boot_next = (ld_next == L_DONE) || (ld_next == L_IDLE && !prog_s && warm[1]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ld_state    <= L_IDLE;
            boot_q      <= 1'b0;
            addr        <= '0;
            count       <= '0;
            idx         <= '0;
            word        <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            ld_state <= ld_next;
            boot_q   <= boot_next;
            if (frame_ev)  frame_err  <= 1'b1;
            if (parity_ev) parity_err <= 1'b1;
            case (ld_state)
                L_IDLE: if (prog_s) begin
                    addr        <= '0;
                    count       <= '0;
                    idx         <= '0;
                    word        <= '0;
                    frame_err   <= 1'b0;
                    parity_err  <= 1'b0;
                    overrun_err <= 1'b0;
                end
                L_LOAD: if (prog_s && byte_valid) begin
                    word <= word_next;
                    idx  <= last_byte ? 4'd0 : idx + 4'd1;
                end
                L_WRITE: begin
                    if (byte_valid) overrun_err <= 1'b1;
                    if (accept) begin
                        addr <= addr + ADDR_W'(1);
                        if (count != '1) count <= count + (ADDR_W+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we_o      = (ld_state == L_WRITE);
    assign mem_addr_o    = addr;
    assign mem_wdata_o   = word;
    assign boot_o        = boot_q;
    assign frame_err_o   = frame_err;
    assign parity_err_o  = parity_err;
    assign overrun_err_o = overrun_err;
    assign word_count_o  = count;

endmodule

// File: tb/tb_prog_uart_loader.sv
// Testbench for prog_uart_loader: drives UART frames, models expected memory
// writes as a queue of {address, data} and checks every write-request cycle.
module tb_prog_uart_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] clk_per_bit;
    logic        rx_i, prog_i, parity_en, parity_odd;
    logic        mem_we_o;
    logic [1:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic        boot_o, frame_err_o, parity_err_o, overrun_err_o;
    logic [2:0]  word_count_o;

    prog_uart_loader #(
        .WORD_W(32), .ADDR_W(2), .DIV_W(16), .EOP_WORD(32'h0000_0FFF)
    ) dut (
        .clock(clock), .reset(reset), .clk_per_bit(clk_per_bit), .rx_i(rx_i),
        .prog_i(prog_i), .parity_en(parity_en), .parity_odd(parity_odd),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .boot_o(boot_o), .frame_err_o(frame_err_o),
        .parity_err_o(parity_err_o), .overrun_err_o(overrun_err_o),
        .word_count_o(word_count_o)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    logic [33:0] exp_q[$];
    int          m_addr = 0;
    int          m_count = 0;
    logic [1:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    int          ready_mode = 0;   // 0 always ready, 1 random short stalls, 2 stalled

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic int eff_div();
        return (clk_per_bit < 16'd4) ? 4 : int'(clk_per_bit);
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stopb);
        int e;
        e = eff_div();
        rx_i = 1'b0; cyc(e);
        for (int i = 0; i < 8; i++) begin rx_i = b[i]; cyc(e); end
        if (parity_en) begin rx_i = pbit; cyc(e); end
        rx_i = stopb; cyc(e);
        rx_i = 1'b1; cyc(2 * e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, (^b) ^ parity_odd, 1'b1);
    endtask

    task automatic expect_write(input logic [31:0] w);
        exp_q.push_back({2'(m_addr), w});
        m_addr = (m_addr + 1) % 4;
        if (m_count < 7) m_count++;
    endtask

    task automatic send_word(input logic [31:0] w, input bit writes);
        for (int k = 0; k < 4; k++) begin
            if (k == 3 && writes) expect_write(w);
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic send_eop();
        send_word(32'h0000_0FFF, 1'b0);
    endtask

    task automatic arm();
        prog_i = 1'b1; m_addr = 0; m_count = 0; cyc(4);
    endtask

    task automatic disarm();
        prog_i = 1'b0; cyc(4);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc(1);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, 64'(mem_we_o), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
        chk({tag, "_boot"}, 64'(boot_o), 64'd0);
        chk({tag, "_errs"}, 64'({frame_err_o, parity_err_o, overrun_err_o}), 64'd0);
        chk({tag, "_count"}, 64'(word_count_o), 64'd0);
    endtask

    task automatic chk_end(input string tag, input logic [2:0] errs);
        chk({tag, "_boot"}, 64'(boot_o), 64'd1);
        chk({tag, "_count"}, 64'(word_count_o), 64'(m_count));
        chk({tag, "_errs"}, 64'({frame_err_o, parity_err_o, overrun_err_o}), 64'(errs));
    endtask

    task automatic checker_loop();
        forever begin
            @(negedge clock);
            if (reset && mem_we_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%08h, required no write",
                             mem_addr_o, mem_wdata_o);
                end else begin
                    chk("write_addr", 64'(mem_addr_o), 64'(exp_q[0][33:32]));
                    chk("write_data", 64'(mem_wdata_o), 64'(exp_q[0][31:0]));
                    if (mem_ready_i) begin
                        last_addr = mem_addr_o;
                        last_data = mem_wdata_o;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic ready_loop();
        int lowrun;
        lowrun = 0;
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                1: begin
                    if (lowrun >= 4 || $urandom_range(2, 0) != 0) begin
                        mem_ready_i = 1'b1; lowrun = 0;
                    end else begin
                        mem_ready_i = 1'b0; lowrun++;
                    end
                end
                2: mem_ready_i = 1'b0;
                default: mem_ready_i = 1'b1;
            endcase
        end
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        reset = 1'b0; rx_i = 1'b1; prog_i = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
        clk_per_bit = 16'd16; mem_ready_i = 1'b1;
        fork
            checker_loop();
            ready_loop();
            begin
                #900000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // reset state and boot release timing
        cyc(3);
        chk_zero("reset");
        reset = 1'b1;
        cyc(2);
        chk("boot_early", 64'(boot_o), 64'd0);
        cyc(2);
        chk("boot_release", 64'(boot_o), 64'd1);

        // basic load
        arm();
        chk("load_boot", 64'(boot_o), 64'd0);
        send_word(32'h1234_5678, 1'b1);
        wait_drain("basic_w0");
        chk("basic_addr0", 64'(last_addr), 64'd0);
        chk("basic_data0", 64'(last_data), 64'h1234_5678);
        send_word(32'hDEAD_BEEF, 1'b1);
        send_eop();
        wait_drain("basic_drain");
        chk("basic_addr1", 64'(last_addr), 64'd1);
        chk("basic_data1", 64'(last_data), 64'hDEAD_BEEF);
        chk("basic_count", 64'(word_count_o), 64'd2);
        chk_end("basic", 3'b000);
        disarm();

        // back-pressure with an overrun byte during the stall
        clk_per_bit = 16'd4;
        arm();
        ready_mode = 2;
        send_word(32'hA1B2_C3D4, 1'b1);
        for (int i = 0; i < 200 && !mem_we_o; i++) cyc(1);
        chk("bp_we_pending", 64'(mem_we_o), 64'd1);
        send_byte(8'h5A);
        chk("bp_still_pending", 64'(mem_we_o), 64'd1);
        chk("bp_overrun", 64'(overrun_err_o), 64'd1);
        chk("bp_count_stalled", 64'(word_count_o), 64'd0);
        ready_mode = 0;
        wait_drain("bp_drain0");
        send_word(32'h0102_0304, 1'b1);
        send_eop();
        wait_drain("bp_drain1");
        chk_end("bp", 3'b001);
        disarm();

        // parity (odd): 0x01 with parity 0 good, 0x03 with parity 0 bad
        clk_per_bit = 16'd8; parity_en = 1'b1; parity_odd = 1'b1;
        arm();
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h03, 1'b0, 1'b1);
        chk("par_flag", 64'(parity_err_o), 64'd1);
        send_byte(8'h22);
        send_byte(8'h33);
        expect_write(32'h4433_2201);
        send_byte(8'h44);
        send_eop();
        wait_drain("par_drain");
        chk("par_data", 64'(last_data), 64'h4433_2201);
        chk_end("par", 3'b010);
        parity_en = 1'b0; parity_odd = 1'b0;
        disarm();

        // line faults: short glitch, then a frame with a low stop bit
        clk_per_bit = 16'd16;
        arm();
        rx_i = 1'b0; cyc(3); rx_i = 1'b1; cyc(40);
        chk("glitch_flags", 64'({frame_err_o, parity_err_o, overrun_err_o}), 64'd0);
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("frame_flag", 64'(frame_err_o), 64'd1);
        send_word(32'hCAFE_F00D, 1'b1);
        send_eop();
        wait_drain("frame_drain");
        chk("frame_data", 64'(last_data), 64'hCAFE_F00D);
        chk_end("frame", 3'b100);
        disarm();

        // abort mid-word and re-arm
        clk_per_bit = 16'd8;
        arm();
        send_byte(8'h11);
        send_byte(8'h22);
        prog_i = 1'b0;
        cyc(6);
        chk("abort_boot", 64'(boot_o), 64'd1);
        chk("abort_we", 64'(mem_we_o), 64'd0);
        arm();
        chk("rearm_boot", 64'(boot_o), 64'd0);
        send_word(32'h0BAD_C0DE, 1'b1);
        send_eop();
        wait_drain("rearm_drain");
        chk("rearm_addr", 64'(last_addr), 64'd0);
        chk("rearm_data", 64'(last_data), 64'h0BAD_C0DE);
        chk_end("rearm", 3'b000);
        disarm();

        // address wrap and count saturation
        clk_per_bit = 16'd4;
        arm();
        for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i), 1'b1);
        wait_drain("wrap_drain");
        chk("wrap_addr", 64'(last_addr), 64'd0);
        chk("wrap_count", 64'(word_count_o), 64'd5);
        for (int i = 5; i < 8; i++) send_word(32'h1000_0000 + 32'(i), 1'b1);
        wait_drain("sat_drain");
        chk("sat_count", 64'(word_count_o), 64'd7);
        send_eop();
        chk_end("sat", 3'b000);
        disarm();

        // randomized loads: divisor (including values below 4), parity, stalls
        ready_mode = 1;
        for (int r = 0; r < 5; r++) begin
            clk_per_bit = 16'($urandom_range(10, 0));
            parity_en = 1'($urandom_range(1, 0));
            parity_odd = 1'($urandom_range(1, 0));
            arm();
            n = $urandom_range(4, 1);
            for (int i = 0; i < n; i++) begin
                w = $urandom();
                if (w == 32'h0000_0FFF) w = w ^ 32'd1;
                send_word(w, 1'b1);
            end
            send_eop();
            wait_drain("rand_drain");
            chk_end("rand", 3'b000);
            disarm();
        end
        ready_mode = 0; parity_en = 1'b0; parity_odd = 1'b0;

        // reset during a stalled write
        clk_per_bit = 16'd8;
        arm();
        ready_mode = 2;
        send_word(32'h7777_8888, 1'b1);
        for (int i = 0; i < 200 && !mem_we_o; i++) cyc(1);
        chk("rst_we_before", 64'(mem_we_o), 64'd1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk_zero("rst_write");
        ready_mode = 0;
        cyc(3);
        reset = 1'b1;
        cyc(4);

        // reset in the middle of a byte
        fork
            send_byte(8'h5A);
            begin
                cyc(30);
                reset = 1'b0;
                #1;
                chk_zero("rst_byte");
            end
        join
        prog_i = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(6);
        chk("rst_reboot", 64'(boot_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
